// File: rtl/pico_io_pkg.sv
// Shared definitions for the PicoBlaze I/O port bank: IRQ state encoding, default map, limits.
// Latency: n/a. Backpressure: n/a.
package pico_io_pkg;

  typedef enum logic [1:0] {
    IRQ_IDLE    = 2'd0,
    IRQ_REQ     = 2'd1,
    IRQ_SERVICE = 2'd2
  } irq_state_t;

  localparam int MAX_OUT = 16;
  localparam int MAX_IN  = 8;

  localparam logic [7:0] DEF_OUT_BASE    = 8'h00;
  localparam logic [7:0] DEF_IN_BASE     = 8'h10;
  localparam logic [7:0] DEF_STATUS_ADDR = 8'h20;
  localparam logic [7:0] DEF_MASK_ADDR   = 8'h21;
  localparam logic [7:0] DEF_OUT_RESET   = 8'h00;

  // True when the port spans [a_base, a_base+a_len) and [b_base, b_base+b_len) share an address.
  function automatic bit spans_overlap(input int a_base, input int a_len,
                                       input int b_base, input int b_len);
    return (a_base < b_base + b_len) && (b_base < a_base + a_len);
  endfunction

endpackage

// File: rtl/pico_io_sync.sv
// One input byte channel: 2-flop synchroniser, history flop and change flag.
// Latency: pin change visible on byte_dat after 2 edges, changed high right after. Backpressure: none.
module pico_io_sync
  import pico_io_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] pin,
  output logic [7:0] byte_dat,
  output logic       changed
);

  logic [7:0] sync1;
  logic [7:0] sync2;
  logic [7:0] sync3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 8'h00;
      sync2 <= 8'h00;
      sync3 <= 8'h00;
    end else begin
      sync1 <= pin;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  assign byte_dat = sync2;
  assign changed  = (sync2 != sync3);

endmodule

// File: rtl/pico_io_bank.sv
// Parametrised KCPSM6 port bank: output regs, synchronised inputs, change status, mask + IRQ (PICO_IO_IRQ_EN).
// Latency: writes visible 1 cycle after strobe, in_port registered 1 cycle after port_id. Backpressure: none.
module pico_io_bank
  import pico_io_pkg::*;
#(
  parameter int         NUM_OUT     = 4,
  parameter int         NUM_IN      = 4,
  parameter logic [7:0] OUT_BASE    = DEF_OUT_BASE,
  parameter logic [7:0] IN_BASE     = DEF_IN_BASE,
  parameter logic [7:0] STATUS_ADDR = DEF_STATUS_ADDR,
  parameter logic [7:0] MASK_ADDR   = DEF_MASK_ADDR,
  parameter logic [7:0] OUT_RESET   = DEF_OUT_RESET
) (
  input  logic                  clk,
  input  logic                  cpu_reset,
  input  logic [7:0]            port_id,
  input  logic [7:0]            out_port,
  input  logic                  write_strobe,
  input  logic                  k_write_strobe,
  input  logic                  read_strobe,
  output logic [7:0]            in_port,
  input  logic [8*NUM_IN-1:0]   pins_in,
  output logic [8*NUM_OUT-1:0]  pins_out,
  output logic                  interrupt,
  input  logic                  interrupt_ack
);

  localparam int OB = int'(OUT_BASE);
  localparam int IB = int'(IN_BASE);
  localparam int SA = int'(STATUS_ADDR);
  localparam int MA = int'(MASK_ADDR);

  // Address map sanity: any overlap or out-of-range span stops elaboration.
  if (NUM_OUT < 1 || NUM_OUT > MAX_OUT) begin : g_bad_num_out
    $error("pico_io_bank: NUM_OUT out of range");
  end
  if (NUM_IN < 1 || NUM_IN > MAX_IN) begin : g_bad_num_in
    $error("pico_io_bank: NUM_IN out of range");
  end
  if (OB + NUM_OUT > 256 || IB + NUM_IN > 256) begin : g_bad_span
    $error("pico_io_bank: port span runs past 8'hFF");
  end
  if (spans_overlap(OB, NUM_OUT, IB, NUM_IN) ||
      spans_overlap(OB, NUM_OUT, SA, 1) ||
      spans_overlap(OB, NUM_OUT, MA, 1) ||
      spans_overlap(IB, NUM_IN, SA, 1) ||
      spans_overlap(IB, NUM_IN, MA, 1) ||
      (SA == MA)) begin : g_bad_map
    $error("pico_io_bank: overlapping port address map");
  end

  logic [7:0]        sync_byte [NUM_IN];
  logic [NUM_IN-1:0] changed;

  for (genvar i = 0; i < NUM_IN; i++) begin : g_in
    pico_io_sync u_sync (
      .clk      (clk),
      .rst      (cpu_reset),
      .pin      (pins_in[8*i +: 8]),
      .byte_dat (sync_byte[i]),
      .changed  (changed[i])
    );
  end

  // Output registers; a plain OUTPUT strobe shadows a coincident OUTPUTK.
  logic [7:0] out_reg [NUM_OUT];

  always_ff @(posedge clk or posedge cpu_reset) begin
    if (cpu_reset) begin
      for (int i = 0; i < NUM_OUT; i++) out_reg[i] <= OUT_RESET;
    end else if (write_strobe) begin
      for (int i = 0; i < NUM_OUT; i++)
        if (port_id == OUT_BASE + 8'(i)) out_reg[i] <= out_port;
    end else if (k_write_strobe) begin
      for (int i = 0; i < NUM_OUT; i++)
        if (port_id[3:0] == 4'(i)) out_reg[i] <= out_port;
    end
  end

  for (genvar i = 0; i < NUM_OUT; i++) begin : g_out
    assign pins_out[8*i +: 8] = out_reg[i];
  end

  // Read-to-clear drops only bits already held; a change landing this cycle survives.
  logic [NUM_IN-1:0] status;
  logic              status_clr;
  logic [7:0]        status_rd_dat;

  assign status_clr = read_strobe && (port_id == STATUS_ADDR);

  always_ff @(posedge clk or posedge cpu_reset) begin
    if (cpu_reset) status <= '0;
    else           status <= (status_clr ? '0 : status) | changed;
  end

  always_comb begin
    status_rd_dat = 8'h00;
    status_rd_dat[NUM_IN-1:0] = status;
  end

  logic [7:0] mask_rd_dat;

`ifdef PICO_IO_IRQ_EN
  logic [NUM_IN-1:0] mask;
  logic              pend;
  irq_state_t        irq_state;
  irq_state_t        irq_state_nxt;

  always_ff @(posedge clk or posedge cpu_reset) begin
    if (cpu_reset)
      mask <= '0;
    else if (write_strobe && (port_id == MASK_ADDR))
      mask <= out_port[NUM_IN-1:0];
  end

  always_comb begin
    mask_rd_dat = 8'h00;
    mask_rd_dat[NUM_IN-1:0] = mask;
  end

  assign pend = |(status & mask);

  always_ff @(posedge clk or posedge cpu_reset) begin
    if (cpu_reset) irq_state <= IRQ_IDLE;
    else           irq_state <= irq_state_nxt;
  end

  // SERVICE holds off re-requesting until the ISR has cleared the pending status.
  always_comb begin
    irq_state_nxt = irq_state;
    interrupt     = 1'b0;
    unique case (irq_state)
      IRQ_IDLE:    if (pend) irq_state_nxt = IRQ_REQ;
      IRQ_REQ: begin
        interrupt = 1'b1;
        if (interrupt_ack) irq_state_nxt = IRQ_SERVICE;
      end
      IRQ_SERVICE: if (!pend) irq_state_nxt = IRQ_IDLE;
      default:     irq_state_nxt = IRQ_IDLE;
    endcase
  end
`else
  logic unused_irq_ack;

  assign unused_irq_ack = interrupt_ack;
  assign mask_rd_dat    = 8'h00;
  assign interrupt      = 1'b0;
`endif

  logic [7:0] rd_dat;

  always_comb begin
    rd_dat = 8'h00;
    if (port_id == STATUS_ADDR)    rd_dat = status_rd_dat;
    else if (port_id == MASK_ADDR) rd_dat = mask_rd_dat;
    for (int i = 0; i < NUM_IN; i++)
      if (port_id == IN_BASE + 8'(i)) rd_dat = sync_byte[i];
    for (int i = 0; i < NUM_OUT; i++)
      if (port_id == OUT_BASE + 8'(i)) rd_dat = out_reg[i];
  end

  always_ff @(posedge clk or posedge cpu_reset) begin
    if (cpu_reset) in_port <= 8'h00;
    else           in_port <= rd_dat;
  end

endmodule
